fb_cmd_controller: RTL and testbench
====================================

Name: fb_cmd_controller

Overview:
Command-driven sequencer for the 128x8-page (1024-byte) display framebuffer held in an external single-port synchronous RAM. It parses the UART byte stream into position, write, fill and read-sync commands. It arbitrates the single RAM port between the display's sequential read stream and UART/fill writes. It sits between the uart receiver, the display driver's d_read/d_data interface and the framebuffer RAM.

Parameters:
PAGES, 8, display pages (rows of 8 pixels)
COLS, 128, columns per page
ADDR_W, 10, framebuffer address width; must equal log2(PAGES*COLS)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous reset, active low
uart_received  in  1  one-cycle strobe: uart_rx_byte valid
uart_rx_byte  in  8  received byte
d_read  in  1  display requests next framebuffer byte
d_data  out  8  byte returned to display
d_data_ready  out  1  one-cycle strobe: d_data valid
fb_en  out  1  RAM access enable
fb_we  out  1  RAM write enable (qualified by fb_en)
fb_addr  out  ADDR_W  RAM address
fb_wdata  out  8  RAM write data
fb_rdata  in  8  RAM read data, valid the cycle after the access edge
busy  out  1  high while FILLING or a write is pending
overrun  out  1  one-cycle strobe: UART byte dropped
cmd_error  out  1  one-cycle strobe: unknown opcode

Behaviour:
- Reset: all outputs 0; rd_idx=0, wr_idx=0, state=IDLE, pending write cleared. Reset mid-fill or mid-write aborts it with no further RAM writes.
- Opcodes: 0xA0 SET_POS (+page, +col); 0xA1 WRITE (+len, +len data bytes, len 0 means 256); 0xA2 FILL (+value); 0xA3 SYNC (rd_idx<=0). Any other byte in IDLE: cmd_error pulse, stay IDLE.
- FSM: IDLE -> POS_PAGE -> POS_COL -> IDLE; IDLE -> WR_LEN -> WR_DATA (count down) -> IDLE; IDLE -> FILL_VAL -> FILLING -> IDLE. SYNC takes effect on the opcode's cycle; an in-flight read still completes.
- SET_POS: wr_idx = page[2:0]*COLS + col[6:0]; upper bits ignored.
- WR_DATA: each byte loads a 1-entry pending-write buffer at wr_idx; wr_idx increments modulo 1024 (1023 -> 0).
- FILLING: writes value to addresses 0..1023 in order, one per granted cycle; on completion wr_idx=0, state IDLE.
- Arbitration: read has strict priority. A pending or fill write issues only on a cycle where d_read=0. Continuous d_read stalls writes indefinitely; this is accepted.
- Read pipeline: d_read high in cycle t -> registered fb_en=1, fb_we=0, fb_addr=rd_idx in t+1 -> d_data=fb_rdata, d_data_ready=1 in t+2. Back-to-back d_read sustains 1 byte/cycle. rd_idx increments per d_read, wrapping 1023 -> 0.
- Write issue: registered fb_en=1, fb_we=1, fb_addr/fb_wdata from the buffer; the buffer clears on the same edge.
- Overrun: a data byte arriving while the buffer is still full, or any uart_received while FILLING, is dropped. It pulses overrun and does not advance wr_idx or the count. An opcode or parameter byte is never blocked.
- Same-cycle uart_received and d_read: both accepted; the write is deferred.

Decomposition:
- fb_pkg: opcode constants, PAGES/COLS/ADDR_W defaults, FSM state encoding.
- Sub-module fb_port_arbiter: read-priority grant, registered RAM port, 2-stage read pipeline (d_data/d_data_ready), rd_idx counter.
- The parser FSM and wr_idx stay in the top level.

Test Plan:
- Reset with rst_n=0 mid-FILLING (addr 300) -> next cycle all outputs 0; no fb_we after release; rd_idx=0.
- Bytes A0,02,05,A1,03,11,22,33 -> RAM writes 0x11@261, 0x22@262, 0x33@263; busy low afterward.
- Bytes A0,07,7F,A1,02,AA,BB -> 0xAA@1023, 0xBB@0 (wrap).
- Bytes A2,FF with d_read held high for cycles 10..19 -> no fb_we in reads' grant cycles; 1024 writes of 0xFF total, addresses 0..1023 once each; then IDLE.
- A3, then 1025 back-to-back d_read -> d_data_ready pulses 2 cycles after each request; addresses 0..1023 then 0.
- Byte 0x55 in IDLE -> one cmd_error pulse; during FILLING any byte -> one overrun pulse; fill unaffected.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared constants for the framebuffer command controller: geometry defaults,
// UART opcodes and the parser state encoding.
package fb_pkg;

  localparam int PAGES_DEF  = 8;
  localparam int COLS_DEF   = 128;
  localparam int ADDR_W_DEF = 10;

  localparam logic [7:0] OP_SET_POS = 8'hA0;
  localparam logic [7:0] OP_WRITE   = 8'hA1;
  localparam logic [7:0] OP_FILL    = 8'hA2;
  localparam logic [7:0] OP_SYNC    = 8'hA3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_POS_PAGE,
    ST_POS_COL,
    ST_WR_LEN,
    ST_WR_DATA,
    ST_FILL_VAL,
    ST_FILLING
  } fb_state_e;

endpackage

// File: rtl/fb_port_arbiter.sv
// Single RAM port owner: display reads win, writes fill idle slots. Also runs
// the display read index and the two-stage read return pipeline.
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_d_read,
  input  logic              i_sync,
  input  logic              i_wr_req,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]        i_wr_data,
  output logic              o_wr_gnt,
  output logic              o_fb_en,
  output logic              o_fb_we,
  output logic [ADDR_W-1:0] o_fb_addr,
  output logic [7:0]        o_fb_wdata,
  input  logic [7:0]        i_fb_rdata,
  output logic [7:0]        o_d_data,
  output logic              o_d_data_ready
);

  logic [ADDR_W-1:0] r_rd_idx;
  logic [ADDR_W-1:0] r_fb_addr;
  logic [7:0]        r_fb_wdata;
  logic              r_fb_en;
  logic              r_fb_we;
  logic [2:1]        r_vld_pipe;

  assign o_wr_gnt = i_wr_req & ~i_d_read;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_idx   <= '0;
      r_fb_addr  <= '0;
      r_fb_wdata <= '0;
      r_fb_en    <= 1'b0;
      r_fb_we    <= 1'b0;
      r_vld_pipe <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[1], i_d_read};
      r_fb_en    <= i_d_read | o_wr_gnt;
      if (i_d_read) begin
        r_fb_we   <= 1'b0;
        r_fb_addr <= r_rd_idx;
      end else if (o_wr_gnt) begin
        r_fb_we    <= 1'b1;
        r_fb_addr  <= i_wr_addr;
        r_fb_wdata <= i_wr_data;
      end else begin
        r_fb_we <= 1'b0;
      end
      // A read issued alongside SYNC uses the old index; the next one starts at 0.
      if (i_sync)
        r_rd_idx <= '0;
      else if (i_d_read)
        r_rd_idx <= r_rd_idx + ADDR_W'(1);
    end
  end

  assign o_fb_en        = r_fb_en;
  assign o_fb_we        = r_fb_we;
  assign o_fb_addr      = r_fb_addr;
  assign o_fb_wdata     = r_fb_wdata;
  // RAM data lands the cycle after the access edge, so it is forwarded unregistered.
  assign o_d_data_ready = r_vld_pipe[2];
  assign o_d_data       = r_vld_pipe[2] ? i_fb_rdata : 8'h00;

endmodule

// File: rtl/fb_cmd_controller.sv
// UART command parser for the display framebuffer: position, burst write,
// fill and read-sync commands, sharing one RAM port with the display reader.
module fb_cmd_controller
  import fb_pkg::*;
#(
  parameter int PAGES  = PAGES_DEF,
  parameter int COLS   = COLS_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_received,
  input  logic [7:0]        uart_rx_byte,
  input  logic              d_read,
  output logic [7:0]        d_data,
  output logic              d_data_ready,
  output logic              fb_en,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata,
  output logic              busy,
  output logic              overrun,
  output logic              cmd_error
);

  localparam int PAGE_W = $clog2(PAGES);
  localparam int COL_W  = $clog2(COLS);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PAGES * COLS - 1);

  fb_state_e         r_state;
  logic [ADDR_W-1:0] r_wr_idx;
  logic [ADDR_W-1:0] r_pend_addr;
  logic [7:0]        r_pend_data;
  logic              r_pend_vld;
  logic [7:0]        r_fill_val;
  logic [8:0]        r_cnt;
  logic [PAGE_W-1:0] r_page;
  logic              r_overrun;
  logic              r_cmd_error;

  logic              w_fill_req;
  logic              w_wr_req;
  logic              w_wr_gnt;
  logic              w_sync;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [7:0]        w_wr_data;

  // A leftover burst byte drains before the fill starts issuing.
  assign w_fill_req = (r_state == ST_FILLING) & ~r_pend_vld;
  assign w_wr_req   = r_pend_vld | w_fill_req;
  assign w_wr_addr  = r_pend_vld ? r_pend_addr : r_wr_idx;
  assign w_wr_data  = r_pend_vld ? r_pend_data : r_fill_val;
  assign w_sync     = uart_received & (r_state == ST_IDLE) & (uart_rx_byte == OP_SYNC);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_wr_idx    <= '0;
      r_pend_addr <= '0;
      r_pend_data <= '0;
      r_pend_vld  <= 1'b0;
      r_fill_val  <= '0;
      r_cnt       <= '0;
      r_page      <= '0;
      r_overrun   <= 1'b0;
      r_cmd_error <= 1'b0;
    end else begin
      r_overrun   <= 1'b0;
      r_cmd_error <= 1'b0;

      if (w_wr_gnt) begin
        if (r_pend_vld) begin
          r_pend_vld <= 1'b0;
        end else begin
          r_wr_idx <= r_wr_idx + ADDR_W'(1);
          if (r_wr_idx == LAST_ADDR)
            r_state <= ST_IDLE;
        end
      end

      if (uart_received) begin
        unique case (r_state)
          ST_IDLE: begin
            unique case (uart_rx_byte)
              OP_SET_POS: r_state <= ST_POS_PAGE;
              OP_WRITE:   r_state <= ST_WR_LEN;
              OP_FILL:    r_state <= ST_FILL_VAL;
              OP_SYNC:    r_state <= ST_IDLE;
              default:    r_cmd_error <= 1'b1;
            endcase
          end
          ST_POS_PAGE: begin
            r_page  <= uart_rx_byte[PAGE_W-1:0];
            r_state <= ST_POS_COL;
          end
          ST_POS_COL: begin
            r_wr_idx <= ADDR_W'(r_page * COLS) + ADDR_W'(uart_rx_byte[COL_W-1:0]);
            r_state  <= ST_IDLE;
          end
          ST_WR_LEN: begin
            r_cnt   <= (uart_rx_byte == 8'h00) ? 9'd256 : {1'b0, uart_rx_byte};
            r_state <= ST_WR_DATA;
          end
          ST_WR_DATA: begin
            if (r_pend_vld) begin
              r_overrun <= 1'b1;
            end else begin
              r_pend_vld  <= 1'b1;
              r_pend_addr <= r_wr_idx;
              r_pend_data <= uart_rx_byte;
              r_wr_idx    <= r_wr_idx + ADDR_W'(1);
              r_cnt       <= r_cnt - 9'd1;
              if (r_cnt == 9'd1)
                r_state <= ST_IDLE;
            end
          end
          ST_FILL_VAL: begin
            r_fill_val <= uart_rx_byte;
            r_wr_idx   <= '0;
            r_state    <= ST_FILLING;
          end
          ST_FILLING: r_overrun <= 1'b1;
          default:    r_state   <= ST_IDLE;
        endcase
      end
    end
  end

  assign busy      = (r_state == ST_FILLING) | r_pend_vld;
  assign overrun   = r_overrun;
  assign cmd_error = r_cmd_error;

  fb_port_arbiter #(
    .ADDR_W(ADDR_W)
  ) u_arb (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_d_read      (d_read),
    .i_sync        (w_sync),
    .i_wr_req      (w_wr_req),
    .i_wr_addr     (w_wr_addr),
    .i_wr_data     (w_wr_data),
    .o_wr_gnt      (w_wr_gnt),
    .o_fb_en       (fb_en),
    .o_fb_we       (fb_we),
    .o_fb_addr     (fb_addr),
    .o_fb_wdata    (fb_wdata),
    .i_fb_rdata    (fb_rdata),
    .o_d_data      (d_data),
    .o_d_data_ready(d_data_ready)
  );

endmodule

// File: tb/tb_fb_cmd_controller.sv
// Bench for fb_cmd_controller: behavioural RAM, command-level reference model,
// randomized payloads and read/write interleaving.
module tb_fb_cmd_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       uart_received;
  logic [7:0] uart_rx_byte;
  logic       d_read;
  logic [7:0] d_data;
  logic       d_data_ready;
  logic       fb_en;
  logic       fb_we;
  logic [9:0] fb_addr;
  logic [7:0] fb_wdata;
  logic [7:0] fb_rdata;
  logic       busy;
  logic       overrun;
  logic       cmd_error;

  fb_cmd_controller dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .uart_received(uart_received),
    .uart_rx_byte (uart_rx_byte),
    .d_read       (d_read),
    .d_data       (d_data),
    .d_data_ready (d_data_ready),
    .fb_en        (fb_en),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .fb_rdata     (fb_rdata),
    .busy         (busy),
    .overrun      (overrun),
    .cmd_error    (cmd_error)
  );

  always #5 clk = ~clk;

  // External single-port synchronous RAM.
  logic [7:0] ram [1024];
  always @(posedge clk) begin
    if (fb_en) begin
      if (fb_we) ram[fb_addr] <= fb_wdata;
      else       fb_rdata     <= ram[fb_addr];
    end
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observation logs filled by the monitor, consumed by the tests.
  logic [17:0] wq[$];
  logic [17:0] expq[$];
  logic [9:0]  rq[$];
  logic [7:0]  dq[$];
  int          reqq[$];
  int          viol, lat_bad, n_ovr, n_err;
  logic        dr_prev = 1'b0;

  // Reference model: framebuffer contents and the write cursor.
  logic [7:0] mdl [1024];
  int         m_wr;

  always @(negedge clk) begin
    int t;
    if (rst_n === 1'b1) begin
      if (fb_en && fb_we) begin
        wq.push_back({fb_addr, fb_wdata});
        if (dr_prev) viol++;
      end
      if (fb_en && !fb_we) rq.push_back(fb_addr);
      if (d_data_ready) begin
        dq.push_back(d_data);
        if (reqq.size() == 0) lat_bad++;
        else begin
          t = reqq.pop_front();
          if (cyc - t != 2) lat_bad++;
        end
      end
      if (d_read) reqq.push_back(cyc);
      if (overrun) n_ovr++;
      if (cmd_error) n_err++;
    end
    dr_prev = d_read;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs;
    wq.delete(); expq.delete(); rq.delete(); dq.delete();
    viol = 0; lat_bad = 0; n_ovr = 0; n_err = 0;
  endtask

  task automatic send(input logic [7:0] b);
    uart_received = 1'b1;
    uart_rx_byte  = b;
    tick;
    uart_received = 1'b0;
    repeat ($urandom_range(1, 3)) tick;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 5000) begin tick; n++; end
    total++;
    if (busy) begin bad++; $display("FAIL idle_timeout busy=%0b after %0d cycles", busy, n); end
    repeat (3) tick;
  endtask

  task automatic do_setpos(input logic [7:0] p, input logic [7:0] c);
    send(8'hA0); send(p); send(c);
    m_wr = int'(p[2:0]) * 128 + int'(c[6:0]);
  endtask

  task automatic do_write(input int n, input logic [7:0] d0, input logic [7:0] step, input bit rnd);
    logic [7:0] b;
    send(8'hA1);
    send((n == 256) ? 8'h00 : 8'(n));
    for (int i = 0; i < n; i++) begin
      b = rnd ? 8'($urandom) : 8'(d0 + 8'(i) * step);
      send(b);
      expq.push_back({10'(m_wr), b});
      mdl[m_wr] = b;
      m_wr = (m_wr + 1) % 1024;
    end
  endtask

  task automatic test_reset;
    int n = 0;
    rst_n = 1'b0; uart_received = 1'b0; uart_rx_byte = 8'h00; d_read = 1'b0;
    repeat (3) tick;
    total++;
    if ({d_data, d_data_ready, fb_en, fb_we, fb_addr, fb_wdata, busy, overrun, cmd_error} !== '0) begin
      bad++; $display("FAIL reset_outputs fb_en=%0b fb_we=%0b fb_addr=%0d busy=%0b exp all 0", fb_en, fb_we, fb_addr, busy);
    end
    rst_n = 1'b1; tick;
    d_read = 1'b1; repeat (5) tick; d_read = 1'b0; repeat (3) tick;
    send(8'hA2); send(8'h3C);
    while (!(fb_en && fb_we && fb_addr == 10'd300) && n < 2000) begin tick; n++; end
    total++;
    if (n >= 2000) begin bad++; $display("FAIL fill_reach_300 timed out addr=%0d", fb_addr); end
    rst_n = 1'b0; tick;
    total++;
    if ({d_data, d_data_ready, fb_en, fb_we, fb_addr, fb_wdata, busy, overrun, cmd_error} !== '0) begin
      bad++; $display("FAIL reset_midfill fb_en=%0b fb_we=%0b fb_addr=%0d busy=%0b exp all 0", fb_en, fb_we, fb_addr, busy);
    end
    rst_n = 1'b1; clear_logs();
    repeat (40) tick;
    total++;
    if (wq.size() != 0 || busy) begin bad++; $display("FAIL reset_abort writes=%0d busy=%0b exp 0/0", wq.size(), busy); end
    d_read = 1'b1; tick; d_read = 1'b0; repeat (3) tick;
    total++;
    if (rq.size() != 1 || rq[0] !== 10'd0) begin
      bad++; $display("FAIL reset_rd_idx reads=%0d addr=%0d exp 1 read @0", rq.size(), (rq.size() > 0) ? rq[0] : 10'h3FF);
    end
    clear_logs();
    m_wr = 0;
    do_write(1, 8'h5A, 8'h00, 1'b0);
    wait_idle();
    total++;
    if (wq.size() != 1 || wq[0] !== expq[0]) begin bad++; $display("FAIL reset_wr_idx writes=%0d exp 1 at addr 0 data 5a", wq.size()); end
  endtask

  task automatic test_fill;
    int c = 0;
    clear_logs();
    send(8'hA2); send(8'hFF);
    uart_rx_byte = 8'h77;
    while (busy && c < 4000) begin
      d_read = (c >= 10 && c < 20);
      uart_received = (c == 30);
      tick; c++;
    end
    d_read = 1'b0; uart_received = 1'b0;
    repeat (4) tick;
    total++;
    if (busy) begin bad++; $display("FAIL fill_timeout busy=%0b exp 0", busy); end
    total++;
    if (wq.size() != 1024) begin bad++; $display("FAIL fill_count got=%0d exp=1024", wq.size()); end
    else begin
      for (int i = 0; i < 1024; i++) begin
        total++;
        if (wq[i] !== {10'(i), 8'hFF}) begin bad++; $display("FAIL fill_write[%0d] got=%h exp=%h", i, wq[i], {10'(i), 8'hFF}); end
      end
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL fill_read_priority writes_in_read_slots=%0d exp 0", viol); end
    total++;
    if (n_ovr != 1) begin bad++; $display("FAIL fill_overrun pulses=%0d exp 1", n_ovr); end
    total++;
    if (rq.size() != 10 || dq.size() != 10 || lat_bad != 0) begin
      bad++; $display("FAIL fill_reads issued=%0d returned=%0d lat_bad=%0d exp 10/10/0", rq.size(), dq.size(), lat_bad);
    end
    for (int i = 0; i < 1024; i++) mdl[i] = 8'hFF;
    m_wr = 0;
  endtask

  task automatic test_write_pos;
    clear_logs();
    do_setpos(8'h02, 8'h05);
    do_write(3, 8'h11, 8'h11, 1'b0);
    wait_idle();
    total++;
    if (wq.size() != expq.size()) begin bad++; $display("FAIL pos_count got=%0d exp=%0d", wq.size(), expq.size()); end
    else foreach (expq[i]) begin
      total++;
      if (wq[i] !== expq[i]) begin bad++; $display("FAIL pos_write[%0d] got=%h exp=%h", i, wq[i], expq[i]); end
    end
    total++;
    if (expq[0] !== {10'd261, 8'h11}) begin bad++; $display("FAIL pos_model got=%h exp=%h", expq[0], {10'd261, 8'h11}); end
    total++;
    if (busy) begin bad++; $display("FAIL pos_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_wrap;
    clear_logs();
    do_setpos(8'h07, 8'h7F);
    do_write(2, 8'hAA, 8'h11, 1'b0);
    wait_idle();
    total++;
    if (wq.size() != 2 || wq[0] !== {10'd1023, 8'hAA} || wq[1] !== {10'd0, 8'hBB}) begin
      bad++; $display("FAIL wrap writes=%0d first=%h second=%h exp 3ffaa/000bb", wq.size(),
                      (wq.size() > 0) ? wq[0] : 18'h0, (wq.size() > 1) ? wq[1] : 18'h0);
    end
  endtask

  task automatic test_random_writes;
    clear_logs();
    for (int k = 0; k < 5; k++) begin
      do_setpos(8'($urandom), 8'($urandom));
      do_write((k == 2) ? 256 : $urandom_range(1, 6), 8'h00, 8'h00, 1'b1);
    end
    wait_idle();
    total++;
    if (wq.size() != expq.size()) begin bad++; $display("FAIL rnd_count got=%0d exp=%0d", wq.size(), expq.size()); end
    else foreach (expq[i]) begin
      total++;
      if (wq[i] !== expq[i]) begin bad++; $display("FAIL rnd_write[%0d] got=%h exp=%h", i, wq[i], expq[i]); end
    end
  endtask

  task automatic test_sync_reads;
    clear_logs();
    send(8'hA3);
    d_read = 1'b1; repeat (1025) tick; d_read = 1'b0;
    repeat (4) tick;
    total++;
    if (rq.size() != 1025 || dq.size() != 1025) begin
      bad++; $display("FAIL sync_count issued=%0d returned=%0d exp 1025", rq.size(), dq.size());
    end else begin
      for (int i = 0; i < 1025; i++) begin
        total++;
        if (rq[i] !== 10'(i % 1024) || dq[i] !== mdl[i % 1024]) begin
          bad++; $display("FAIL sync_read[%0d] addr=%0d data=%h exp addr=%0d data=%h", i, rq[i], dq[i], i % 1024, mdl[i % 1024]);
        end
      end
    end
    total++;
    if (lat_bad != 0) begin bad++; $display("FAIL sync_latency bad=%0d exp 0", lat_bad); end
  endtask

  task automatic test_cmd_error;
    logic [7:0] b;
    clear_logs();
    send(8'h55); repeat (2) tick;
    total++;
    if (n_err != 1 || busy) begin bad++; $display("FAIL cmd_error_55 pulses=%0d busy=%0b exp 1/0", n_err, busy); end
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      if (b >= 8'hA0 && b <= 8'hA3) b = b ^ 8'h10;
      send(b);
    end
    repeat (2) tick;
    total++;
    if (n_err != 5 || wq.size() != 0) begin bad++; $display("FAIL cmd_error_rnd pulses=%0d writes=%0d exp 5/0", n_err, wq.size()); end
    do_write(1, 8'h00, 8'h00, 1'b1);
    wait_idle();
    total++;
    if (wq.size() != 1 || wq[0] !== expq[0]) begin bad++; $display("FAIL cmd_error_recover writes=%0d exp 1", wq.size()); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] b;
    int n;
    clear_logs();
    do_setpos(8'($urandom), 8'($urandom));
    n = $urandom_range(3, 6);
    send(8'hA1); send(8'(n));
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom);
      d_read = 1'b1; uart_received = 1'b1; uart_rx_byte = b;
      tick;
      d_read = 1'b0; uart_received = 1'b0;
      repeat (3) tick;
      expq.push_back({10'(m_wr), b}); mdl[m_wr] = b; m_wr = (m_wr + 1) % 1024;
    end
    wait_idle();
    total++;
    if (wq.size() != expq.size() || rq.size() != n || lat_bad != 0 || n_ovr != 0) begin
      bad++; $display("FAIL b2b_counts writes=%0d reads=%0d lat_bad=%0d ovr=%0d exp %0d/%0d/0/0",
                      wq.size(), rq.size(), lat_bad, n_ovr, expq.size(), n);
    end else foreach (expq[i]) begin
      total++;
      if (wq[i] !== expq[i]) begin bad++; $display("FAIL b2b_write[%0d] got=%h exp=%h", i, wq[i], expq[i]); end
    end
    // Buffer overrun: second byte dropped while reads hold the port.
    clear_logs();
    do_setpos(8'($urandom), 8'($urandom));
    send(8'hA1); send(8'h03);
    d_read = 1'b1;
    b = 8'($urandom); send(b);
    expq.push_back({10'(m_wr), b}); mdl[m_wr] = b; m_wr = (m_wr + 1) % 1024;
    send(8'($urandom));
    d_read = 1'b0; repeat (2) tick;
    for (int i = 0; i < 2; i++) begin
      b = 8'($urandom); send(b);
      expq.push_back({10'(m_wr), b}); mdl[m_wr] = b; m_wr = (m_wr + 1) % 1024;
    end
    wait_idle();
    total++;
    if (n_ovr != 1) begin bad++; $display("FAIL buf_overrun pulses=%0d exp 1", n_ovr); end
    total++;
    if (wq.size() != 3) begin bad++; $display("FAIL buf_count got=%0d exp=3", wq.size()); end
    else foreach (expq[i]) begin
      total++;
      if (wq[i] !== expq[i]) begin bad++; $display("FAIL buf_write[%0d] got=%h exp=%h", i, wq[i], expq[i]); end
    end
    total++;
    if (viol != 0) begin bad++; $display("FAIL b2b_read_priority got=%0d exp=0", viol); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_write_pos();
    test_wrap();
    test_random_writes();
    test_sync_reads();
    test_cmd_error();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
